// File: rtl/req_grant_arbiter.sv
// Registered N-way arbiter: highest-index or rotating priority, hold-while-requesting,
// forced handover when an owner reaches the hold limit and someone else is waiting.
module req_grant_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned IDX_W    = 2,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned RR       = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             zero,
  output logic             preempt
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [IDX_W-1:0]  last_idx;

  logic              owner_req;
  logic              expiry;
  logic [N-1:0]      sel_mask;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  // Winner selection; on expiry the current owner is masked out so a waiter can take over
  always_comb begin
    owner_req  = (state == BUSY) && req[grant_idx];
    expiry     = owner_req && (hold_cnt == HOLD_LAST);
    sel_mask   = owner_req ? (req & ~grant) : req;
    pick_found = 1'b0;
    pick_idx   = '0;
    if (RR == 0) begin
      // Ascending scan: the last set bit seen is the highest index
      for (int i = 0; i < int'(N); i++) begin
        if (sel_mask[i]) begin
          pick_found = 1'b1;
          pick_idx   = IDX_W'(i);
        end
      end
    end else begin
      // Downward scan with wrap, starting just below the previous winner
      for (int k = 0; k < int'(N); k++) begin
        if (!pick_found && sel_mask[(int'(last_idx) + 2 * int'(N) - 1 - k) % int'(N)]) begin
          pick_found = 1'b1;
          pick_idx   = IDX_W'((int'(last_idx) + 2 * int'(N) - 1 - k) % int'(N));
        end
      end
    end
  end

  // State, hold counter and registered grant outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      last_idx    <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      zero        <= 1'b1;
      preempt     <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state       <= BUSY;
            grant       <= N'(1) << pick_idx;
            grant_idx   <= pick_idx;
            grant_valid <= 1'b1;
            zero        <= 1'b0;
            last_idx    <= pick_idx;
            hold_cnt    <= '0;
          end
        end
        BUSY: begin
          if (owner_req && !expiry) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end else if (pick_found) begin
            // Release or expiry with a waiter: hand over without a dead cycle
            grant     <= N'(1) << pick_idx;
            grant_idx <= pick_idx;
            last_idx  <= pick_idx;
            hold_cnt  <= '0;
            preempt   <= expiry;
          end else if (expiry) begin
            // Nobody else waiting: owner keeps the resource, window restarts
            hold_cnt <= '0;
          end else begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            zero        <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_grant_arbiter.sv
// Bench for req_grant_arbiter: fixed-priority and rotating instances share one request
// vector and are compared each cycle against an arithmetic model of the arbitration rules.
module tb_req_grant_arbiter;

  localparam int MAXH = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;

  logic [3:0] grant0, grant1;
  logic [1:0] idx0, idx1;
  logic       valid0, valid1, zero0, zero1, pre0, pre1;

  int checks = 0;
  int errors = 0;

  // Model state per instance: [0] fixed priority, [1] rotating
  int m_owner[2];
  int m_valid[2];
  int m_cnt[2];
  int m_last[2];
  int m_pre[2];

  req_grant_arbiter #(.N(4), .IDX_W(2), .MAX_HOLD(MAXH), .RR(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant0), .grant_idx(idx0),
    .grant_valid(valid0), .zero(zero0), .preempt(pre0)
  );

  req_grant_arbiter #(.N(4), .IDX_W(2), .MAX_HOLD(MAXH), .RR(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(grant1), .grant_idx(idx1),
    .grant_valid(valid1), .zero(zero1), .preempt(pre1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Selection rule: highest index, or first set bit scanning down from last-1 with wrap
  function automatic int msel(input int m, input logic [3:0] mask);
    int p;
    if (m == 0) begin
      for (int i = 3; i >= 0; i--) if (mask[i]) return i;
    end else begin
      for (int k = 0; k < 4; k++) begin
        p = (m_last[m] + 8 - 1 - k) % 4;
        if (mask[p]) return p;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_owner[m] = 0; m_valid[m] = 0; m_cnt[m] = 0; m_last[m] = 0; m_pre[m] = 0;
    end
  endtask

  task automatic model_step(input logic [3:0] r);
    int w;
    logic [3:0] others;
    for (int m = 0; m < 2; m++) begin
      m_pre[m] = 0;
      if (m_valid[m] == 0) begin
        w = msel(m, r);
        if (w >= 0) begin
          m_owner[m] = w; m_valid[m] = 1; m_cnt[m] = 0; m_last[m] = w;
        end
      end else if (r[m_owner[m]]) begin
        if (m_cnt[m] < MAXH - 1) begin
          m_cnt[m]++;
        end else begin
          others = r;
          others[m_owner[m]] = 1'b0;
          w = msel(m, others);
          if (w >= 0) begin
            m_owner[m] = w; m_last[m] = w; m_pre[m] = 1;
          end
          m_cnt[m] = 0;
        end
      end else begin
        w = msel(m, r);
        if (w >= 0) begin
          m_owner[m] = w; m_last[m] = w; m_cnt[m] = 0;
        end else begin
          m_valid[m] = 0; m_owner[m] = 0; m_cnt[m] = 0;
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_dut(input int m, input logic [3:0] g, input logic [1:0] gi,
                           input logic gv, input logic z, input logic p);
    logic [3:0] eg;
    eg = (m_valid[m] != 0) ? 4'(1 << m_owner[m]) : 4'b0000;
    check($sformatf("rr%0d_grant", m), 32'(g), 32'(eg));
    check($sformatf("rr%0d_idx", m), 32'(gi), (m_valid[m] != 0) ? 32'(m_owner[m]) : 32'd0);
    check($sformatf("rr%0d_valid", m), 32'(gv), 32'(m_valid[m]));
    check($sformatf("rr%0d_zero", m), 32'(z), 32'(m_valid[m] == 0));
    check($sformatf("rr%0d_preempt", m), 32'(p), 32'(m_pre[m]));
  endtask

  task automatic check_all();
    check_dut(0, grant0, idx0, valid0, zero0, pre0);
    check_dut(1, grant1, idx1, valid1, zero1, pre1);
  endtask

  // One clock: model consumes the request seen at the edge, outputs checked 1 time unit later
  task automatic cycle();
    @(posedge clk);
    model_step(req);
    #1;
    check_all();
  endtask

  task automatic run(input logic [3:0] r, input int n);
    req = r;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int pre_seen;
    logic [3:0] r;

    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no requests
    run(4'b0000, 5);

    // Highest of 0101 wins, then handover to 0 with no idle gap
    run(4'b0101, 1);
    check("first_grant_is_2", 32'(grant0), 32'h4);
    run(4'b0001, 1);
    check("handover_to_0", 32'(grant0), 32'h1);
    check("no_idle_gap", 32'(valid0), 32'h1);

    // Owner 1 keeps grant against higher waiter until expiry
    run(4'b0000, 2);
    run(4'b0010, 1);
    run(4'b1010, 6);
    check("owner_holds", 32'(grant0), 32'h2);
    pre_seen = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (pre0) pre_seen++;
    end
    check("expiry_to_3", 32'(grant0), 32'h8);
    check("single_preempt", 32'(pre_seen), 32'd1);

    // Lone requester keeps grant through counter wrap, no preempt
    run(4'b0000, 2);
    pre_seen = 0;
    req = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (pre0 || pre1) pre_seen++;
    end
    check("lone_no_preempt", 32'(pre_seen), 32'd0);

    // All requesting: rotation in RR instance, 3/2 ping-pong in fixed instance
    run(4'b0000, 2);
    run(4'b1111, 40);

    // Randomized requests with holding bias
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] = ~r[$urandom_range(0, 3)];
      run(r, 1);
    end

    // Async reset while owner 3 is granted
    run(4'b0000, 2);
    run(4'b1000, 3);
    check("owner3_before_reset", 32'(grant1), 32'h8);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    req = 4'b0110;
    #2;
    rst_n = 1'b1;
    cycle();
    check("restart_grant", 32'(grant1), 32'h4);
    run(4'b0110, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
